audio_pwm: RTL

Downstream output stage for `audio_wave`: consumes the `level` sample stream and drives the board's mono PWM audio pin and amplifier shutdown line. Samples are latched only at PWM period boundaries, so output edges are glitch-free. Output is scaled by a 3-bit volume. A per-period gain ramp on enable and disable suppresses clicks.

---
 rtl/audio_pwm.sv | 130 +++++++++++++
 1 files changed

// File: rtl/audio_pwm.sv
// audio_pwm: PWM audio output stage. Samples are latched at period boundaries and scaled by (vol+1)/8.
// Define AUDIO_PWM_RAMP_EN to ramp the gain one step per period on enable/disable; otherwise the gain jumps.
module audio_pwm #(
  parameter int BITS = 6
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [BITS-1:0] level,
  input  logic [2:0]      vol,
  input  logic            enable,
  output logic            pwm_out,
  output logic            sd_n,
  output logic            period_start
);

`ifdef AUDIO_PWM_RAMP_EN
  typedef enum logic [1:0] {OFF, RAMP_UP, ON, RAMP_DOWN} state_t;
`else
  typedef enum logic {OFF, ON} state_t;
`endif

  state_t          state_q, state_d;
  logic [BITS-1:0] cnt_q, cnt_d;
  logic [BITS-1:0] duty_q, duty_d;
  logic [3:0]      gain_q, gain_d;
  logic            sd_n_q, sd_n_d;
  logic            pwm_q, pwm_d;
  logic            wrap;
  logic [3:0]      target;
  logic [BITS+3:0] product;
  logic            unused_product;

  assign wrap   = (cnt_q == {BITS{1'b1}});
  assign target = {1'b0, vol} + 4'd1;
  assign cnt_d  = cnt_q + BITS'(1);

`ifdef AUDIO_PWM_RAMP_EN
  logic [3:0] gain_step;

  always_comb begin
    if (gain_q < target)      gain_step = gain_q + 4'd1;
    else if (gain_q > target) gain_step = gain_q - 4'd1;
    else                      gain_step = gain_q;
  end

  // Every transition applies its gain step at the same wrap edge it is taken on.
  always_comb begin
    state_d = state_q;
    gain_d  = gain_q;
    sd_n_d  = sd_n_q;
    if (wrap) begin
      if (!enable) begin
        if (gain_q <= 4'd1) begin
          state_d = OFF;
          gain_d  = 4'd0;
          sd_n_d  = 1'b0;
        end else begin
          state_d = RAMP_DOWN;
          gain_d  = gain_q - 4'd1;
        end
      end else begin
        case (state_q)
          OFF: begin
            gain_d  = 4'd1;
            sd_n_d  = 1'b1;
            state_d = (target == 4'd1) ? ON : RAMP_UP;
          end
          RAMP_UP, RAMP_DOWN: begin
            gain_d  = gain_step;
            state_d = ((gain_q < target) && (gain_step != target)) ? RAMP_UP : ON;
          end
          default: begin
            gain_d  = gain_step;
            state_d = ON;
          end
        endcase
      end
    end
  end
`else
  always_comb begin
    state_d = state_q;
    gain_d  = gain_q;
    sd_n_d  = sd_n_q;
    if (wrap) begin
      if (enable) begin
        state_d = ON;
        gain_d  = target;
        sd_n_d  = 1'b1;
      end else begin
        state_d = OFF;
        gain_d  = 4'd0;
        sd_n_d  = 1'b0;
      end
    end
  end
`endif

  // Duty uses the gain that takes effect this period; level*8/8 tops out at 2^BITS-1.
  always_comb begin
    product = {4'b0000, level} * {{BITS{1'b0}}, gain_d};
    duty_d  = wrap ? product[BITS+2:3] : duty_q;
    pwm_d   = (state_q != OFF) && (cnt_q < duty_q);
  end

  assign unused_product = ^{product[BITS+3], product[2:0]};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q   <= '0;
      state_q <= OFF;
      gain_q  <= 4'd0;
      duty_q  <= '0;
      sd_n_q  <= 1'b0;
      pwm_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      state_q <= state_d;
      gain_q  <= gain_d;
      duty_q  <= duty_d;
      sd_n_q  <= sd_n_d;
      pwm_q   <= pwm_d;
    end
  end

  assign pwm_out      = pwm_q;
  assign sd_n         = sd_n_q;
  assign period_start = reset && (cnt_q == '0);

endmodule
